control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microprogram sequencer of the control unit: holds the current control state, selects the next one.
//  Consumes the 6-bit state from the instruction encoder (taken on NS_ENC), the microinstruction's next-state fields and status.
//  Drives the state register that addresses the control microstore.
//  Provides MOC wait with a watchdog, conditional branching, and an optional one-level call/return.
// PARAMETERS
//  SW          6   state/address width
//  RESET_STATE 0   state loaded on reset
//  TRAP_STATE  61  state forced on watchdog timeout or illegal ns_sel
//  MOC_TIMEOUT 15  max cycles spent in NS_WAIT before trap (1..2^TW-1)
//  TW          4   watchdog counter width
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   reset, synchronous, active-high
//  hold       in   1   freeze: state, watchdog, return reg unchanged
//  enc_state  in   SW  decoded entry state from instruction encoder
//  ns_sel     in   3   next-state select (microinstruction field)
//  cr_addr    in   SW  literal target (microinstruction field)
//  cond_sel   in   2   condition source: 00 true, 01 cond_pass, 10 moc, 11 z_flag
//  inv        in   1   invert selected condition
//  cond_pass  in   1   ARM condition-field test result
//  moc        in   1   memory operation complete
//  z_flag     in   1   ALU zero flag
//  state      out  SW  current control state (registered)
//  in_wait    out  1   ns_sel==NS_WAIT and moc==0 this cycle (combinational)
//  trap       out  1   one-cycle pulse, registered, coincident with state==TRAP_STATE entry
// BEHAVIOUR
//  - Reset: state=RESET_STATE, wdog=0, ret_reg=0, trap=0. Reset beats hold and every ns_sel.
//  - Single-cycle: next state computed combinationally, loaded on next edge; inc = state+1 mod 2^SW (63->0).
//  - c = sel(cond_sel) ^ inv.
//  - NS_ENC 000: enc_state.   NS_INC 001: inc.   NS_JMP 010: cr_addr.
//  - NS_CJMP 011: c ? cr_addr : inc.
//  - NS_CENC 101: c ? enc_state : cr_addr (cond-fail -> fetch).
//  - NS_WAIT 100: moc ? inc : state; wdog++ each waiting cycle; wdog cleared on any non-waiting cycle.
//    wdog==MOC_TIMEOUT-1 and moc==0 -> next=TRAP_STATE, trap=1, wdog=0. moc in same cycle wins (inc, no trap).
//  - hold=1: all registers keep value, trap=0, wdog does not count.
//  - Reset mid-wait: wdog cleared, no trap pulse.
// CONFIGURATION
//  - CTRL_SEQ_CALL_RET_EN defined:
//    NS_CALL 110: ret_reg<=inc, next=cr_addr.   NS_RET 111: next=ret_reg.
//    CALL inside CALL overwrites ret_reg (one level, no stack).
//  - Not defined: 110/111 are illegal -> next=TRAP_STATE, trap=1; no ret_reg flop exists.
// STRUCTURE
//  - Package ctrl_seq_pkg: NS_* and COND_* localparams, SW default, TRAP_STATE/RESET_STATE defaults.
//  - Sub-module seq_next_mux (combinational): condition select, inc, next-state mux, illegal decode.
//  - Top: state reg, wdog counter, ret_reg, trap flop.
// TESTING
//  1 reset=1 with any inputs -> state=0, trap=0; release, ns_sel=INC x3 -> 1,2,3; state=63 INC -> 0.
//  2 state=1, ns_sel=ENC, enc_state=26 -> state=26 next edge.
//    CENC, cond_sel=01, cond_pass=0, cr_addr=1 -> state=1.
//  3 state=20, NS_WAIT, moc low 3 cycles then high -> state 20,20,20,21; in_wait 1,1,1,0; no trap.
//  4 NS_WAIT, moc never -> after 15 cycles state=61, trap one cycle. moc rising on cycle 15 -> state=21, no trap.
//  5 CJMP cond_sel=11 inv=1 z_flag=0 cr_addr=40 -> 40; hold=1 mid-wait 5 cycles -> state/wdog frozen.
//  6 With CTRL_SEQ_CALL_RET_EN: state=10 CALL cr_addr=50 -> 50; RET -> 11.
//    Without the macro: CALL -> state=61, trap=1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared encodings and default geometry for the microprogram sequencer.
package ctrl_seq_pkg;

  localparam int SW_DEF          = 6;
  localparam int RESET_STATE_DEF = 0;
  localparam int TRAP_STATE_DEF  = 61;
  localparam int MOC_TIMEOUT_DEF = 15;
  localparam int TW_DEF          = 4;

  localparam logic [2:0] NS_ENC  = 3'b000;
  localparam logic [2:0] NS_INC  = 3'b001;
  localparam logic [2:0] NS_JMP  = 3'b010;
  localparam logic [2:0] NS_CJMP = 3'b011;
  localparam logic [2:0] NS_WAIT = 3'b100;
  localparam logic [2:0] NS_CENC = 3'b101;
  localparam logic [2:0] NS_CALL = 3'b110;
  localparam logic [2:0] NS_RET  = 3'b111;

  localparam logic [1:0] COND_TRUE = 2'b00;
  localparam logic [1:0] COND_PASS = 2'b01;
  localparam logic [1:0] COND_MOC  = 2'b10;
  localparam logic [1:0] COND_Z    = 2'b11;

endpackage

// File: rtl/control_sequencer_if.sv
// Microinstruction/status bundle into the sequencer and control state back out.
interface control_sequencer_if #(
  parameter int SW = ctrl_seq_pkg::SW_DEF
);
  logic          hold;
  logic [SW-1:0] enc_state;
  logic [2:0]    ns_sel;
  logic [SW-1:0] cr_addr;
  logic [1:0]    cond_sel;
  logic          inv;
  logic          cond_pass;
  logic          moc;
  logic          z_flag;
  logic [SW-1:0] state;
  logic          in_wait;
  logic          trap;

  modport master (
    output hold, enc_state, ns_sel, cr_addr, cond_sel, inv, cond_pass, moc, z_flag,
    input  state, in_wait, trap
  );

  modport slave (
    input  hold, enc_state, ns_sel, cr_addr, cond_sel, inv, cond_pass, moc, z_flag,
    output state, in_wait, trap
  );
endinterface

// File: rtl/control_sequencer_seq_next_mux.sv
// Combinational next-state selection: condition select, increment, ns_sel decode.
// CTRL_SEQ_CALL_RET_EN adds the call/return encodings; otherwise they trap.
module seq_next_mux
  import ctrl_seq_pkg::*;
#(
  parameter int SW         = SW_DEF,
  parameter int TRAP_STATE = TRAP_STATE_DEF
) (
  input  logic [SW-1:0] state,
  input  logic [SW-1:0] enc_state,
  input  logic [SW-1:0] cr_addr,
  input  logic [2:0]    ns_sel,
  input  logic [1:0]    cond_sel,
  input  logic          inv,
  input  logic          cond_pass,
  input  logic          moc,
  input  logic          z_flag,
  input  logic          timeout,
`ifdef CTRL_SEQ_CALL_RET_EN
  input  logic [SW-1:0] ret_addr,
  output logic          call,
`endif
  output logic [SW-1:0] next_state,
  output logic          waiting,
  output logic          trap_req
);

  logic [SW-1:0] inc;
  logic          sel;
  logic          c;

  always_comb begin
    inc = state + SW'(1);
    case (cond_sel)
      COND_TRUE: sel = 1'b1;
      COND_PASS: sel = cond_pass;
      COND_MOC:  sel = moc;
      default:   sel = z_flag;
    endcase
    c = sel ^ inv;
  end

  always_comb begin
    next_state = state;
    waiting    = 1'b0;
    trap_req   = 1'b0;
`ifdef CTRL_SEQ_CALL_RET_EN
    call       = 1'b0;
`endif
    case (ns_sel)
      NS_ENC:  next_state = enc_state;
      NS_INC:  next_state = inc;
      NS_JMP:  next_state = cr_addr;
      NS_CJMP: next_state = c ? cr_addr : inc;
      NS_CENC: next_state = c ? enc_state : cr_addr;
      NS_WAIT: begin
        // A completing memory op on the last allowed cycle still advances normally.
        if (moc) begin
          next_state = inc;
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            next_state = SW'(TRAP_STATE);
            trap_req   = 1'b1;
          end
        end
      end
`ifdef CTRL_SEQ_CALL_RET_EN
      NS_CALL: begin
        call       = 1'b1;
        next_state = cr_addr;
      end
      NS_RET:  next_state = ret_addr;
`else
      NS_CALL, NS_RET: begin
        next_state = SW'(TRAP_STATE);
        trap_req   = 1'b1;
      end
`endif
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microprogram sequencer: state register, MOC watchdog, trap flag and optional
// one-level return register (CTRL_SEQ_CALL_RET_EN).
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int SW          = SW_DEF,
  parameter int RESET_STATE = RESET_STATE_DEF,
  parameter int TRAP_STATE  = TRAP_STATE_DEF,
  parameter int MOC_TIMEOUT = MOC_TIMEOUT_DEF,
  parameter int TW          = TW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.slave bus
);

  logic [SW-1:0] state_q;
  logic [TW-1:0] wdog_q;
  logic          trap_q;
  logic [SW-1:0] next_state;
  logic          waiting;
  logic          trap_req;
  logic          timeout;

  assign timeout = (wdog_q == TW'(MOC_TIMEOUT - 1));

`ifdef CTRL_SEQ_CALL_RET_EN
  logic [SW-1:0] ret_q;
  logic          call;
`endif

  seq_next_mux #(
    .SW         (SW),
    .TRAP_STATE (TRAP_STATE)
  ) u_mux (
    .state      (state_q),
    .enc_state  (bus.enc_state),
    .cr_addr    (bus.cr_addr),
    .ns_sel     (bus.ns_sel),
    .cond_sel   (bus.cond_sel),
    .inv        (bus.inv),
    .cond_pass  (bus.cond_pass),
    .moc        (bus.moc),
    .z_flag     (bus.z_flag),
    .timeout    (timeout),
`ifdef CTRL_SEQ_CALL_RET_EN
    .ret_addr   (ret_q),
    .call       (call),
`endif
    .next_state (next_state),
    .waiting    (waiting),
    .trap_req   (trap_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SW'(RESET_STATE);
      wdog_q  <= '0;
      trap_q  <= 1'b0;
    end else if (bus.hold) begin
      trap_q  <= 1'b0;
    end else begin
      state_q <= next_state;
      trap_q  <= trap_req;
      // Counts consecutive waiting cycles; any other cycle, or the trap itself, restarts it.
      wdog_q  <= (waiting && !trap_req) ? wdog_q + TW'(1) : '0;
    end
  end

`ifdef CTRL_SEQ_CALL_RET_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q <= '0;
    end else if (!bus.hold && call) begin
      ret_q <= state_q + SW'(1);
    end
  end
`endif

  assign bus.state   = state_q;
  assign bus.trap    = trap_q;
  assign bus.in_wait = (bus.ns_sel == NS_WAIT) && !bus.moc;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer (default build; CTRL_SEQ_CALL_RET_EN aware).
module tb_control_sequencer;
  import ctrl_seq_pkg::*;

  typedef struct {
    logic       rst;
    logic       hold;
    logic [2:0] ns;
    logic [5:0] enc;
    logic [5:0] cr;
    logic [1:0] csel;
    logic       inv;
    logic       cp;
    logic       moc;
    logic       z;
    logic [5:0] exp_state;
    logic       exp_trap;
    logic       exp_wait;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic hold, input logic [2:0] ns,
                              input logic [5:0] enc, input logic [5:0] cr, input logic [1:0] csel,
                              input logic inv, input logic cp, input logic moc, input logic z,
                              input logic [5:0] es, input logic et, input logic ew);
    vec_t v;
    v.rst = rst; v.hold = hold; v.ns = ns; v.enc = enc; v.cr = cr; v.csel = csel;
    v.inv = inv; v.cp = cp; v.moc = moc; v.z = z;
    v.exp_state = es; v.exp_trap = et; v.exp_wait = ew;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    reset         = v.rst;
    bus.hold      = v.hold;
    bus.ns_sel    = v.ns;
    bus.enc_state = v.enc;
    bus.cr_addr   = v.cr;
    bus.cond_sel  = v.csel;
    bus.inv       = v.inv;
    bus.cond_pass = v.cp;
    bus.moc       = v.moc;
    bus.z_flag    = v.z;
    #1;
    n_vec++;
    if (bus.in_wait !== v.exp_wait) begin
      n_bad++;
      $display("FAIL %s in_wait: got %0b expected %0b", name, bus.in_wait, v.exp_wait);
    end
    @(posedge clk);
    #1;
    if (bus.state !== v.exp_state) begin
      n_bad++;
      $display("FAIL %s state: got %0d expected %0d", name, bus.state, v.exp_state);
    end
    if (bus.trap !== v.exp_trap) begin
      n_bad++;
      $display("FAIL %s trap: got %0b expected %0b", name, bus.trap, v.exp_trap);
    end
  endtask

  // Short form for sequences that only use ns_sel/cr_addr/moc/hold/reset.
  task automatic step(input logic rst, input logic hold, input logic [2:0] ns, input logic [5:0] cr,
                      input logic moc, input logic [5:0] es, input logic et, input logic ew,
                      input string name);
    apply(mk(rst, hold, ns, 6'd0, cr, 2'd0, 1'b0, 1'b0, moc, 1'b0, es, et, ew), name);
  endtask

  task automatic waits(input int n, input logic [5:0] es, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, NS_WAIT, 6'd0, 1'b0, es, 1'b0, 1'b1, name);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bus.hold = 1'b0; bus.ns_sel = NS_INC; bus.enc_state = '0; bus.cr_addr = '0;
    bus.cond_sel = '0; bus.inv = 1'b0; bus.cond_pass = 1'b0; bus.moc = 1'b0; bus.z_flag = 1'b0;

    // reset, increment, wrap
    tbl.push_back(mk(1, 1, NS_JMP,  7, 33, 3, 1, 1, 1, 1,  0, 0, 0));
    tbl.push_back(mk(1, 0, NS_WAIT, 0,  0, 0, 0, 0, 0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0,  2, 0, 0));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 0, NS_JMP,  0, 63, 0, 0, 0, 0, 0, 63, 0, 0));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0));
    // ENC / CENC
    tbl.push_back(mk(0, 0, NS_JMP,  0,  1, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, NS_ENC, 26,  0, 0, 0, 0, 0, 0, 26, 0, 0));
    tbl.push_back(mk(0, 0, NS_CENC,26,  1, 1, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, NS_CENC,26,  9, 1, 0, 1, 0, 0, 26, 0, 0));
    tbl.push_back(mk(0, 0, NS_CENC,26,  5, 0, 1, 0, 0, 0,  5, 0, 0));
    tbl.push_back(mk(0, 0, NS_CENC,12,  3, 2, 0, 0, 1, 0, 12, 0, 0));
    // short MOC wait
    tbl.push_back(mk(0, 0, NS_JMP,  0, 20, 0, 0, 0, 0, 0, 20, 0, 0));
    tbl.push_back(mk(0, 0, NS_WAIT, 0,  0, 0, 0, 0, 0, 0, 20, 0, 1));
    tbl.push_back(mk(0, 0, NS_WAIT, 0,  0, 0, 0, 0, 0, 0, 20, 0, 1));
    tbl.push_back(mk(0, 0, NS_WAIT, 0,  0, 0, 0, 0, 0, 0, 20, 0, 1));
    tbl.push_back(mk(0, 0, NS_WAIT, 0,  0, 0, 0, 0, 1, 0, 21, 0, 0));
    // CJMP on each condition source
    tbl.push_back(mk(0, 0, NS_CJMP, 0, 40, 3, 1, 0, 0, 0, 40, 0, 0));
    tbl.push_back(mk(0, 0, NS_CJMP, 0, 10, 3, 0, 0, 0, 0, 41, 0, 0));
    tbl.push_back(mk(0, 0, NS_CJMP, 0, 10, 3, 0, 0, 0, 1, 10, 0, 0));
    tbl.push_back(mk(0, 0, NS_CJMP, 0, 30, 1, 0, 0, 0, 0, 11, 0, 0));
    tbl.push_back(mk(0, 0, NS_CJMP, 0,  7, 2, 0, 0, 1, 0,  7, 0, 0));
`ifdef CTRL_SEQ_CALL_RET_EN
    tbl.push_back(mk(0, 0, NS_JMP,  0, 10, 0, 0, 0, 0, 0, 10, 0, 0));
    tbl.push_back(mk(0, 0, NS_CALL, 0, 50, 0, 0, 0, 0, 0, 50, 0, 0));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0, 51, 0, 0));
    tbl.push_back(mk(0, 0, NS_RET,  0,  0, 0, 0, 0, 0, 0, 11, 0, 0));
    tbl.push_back(mk(0, 0, NS_CALL, 0, 20, 0, 0, 0, 0, 0, 20, 0, 0));
    tbl.push_back(mk(0, 0, NS_CALL, 0, 30, 0, 0, 0, 0, 0, 30, 0, 0));
    tbl.push_back(mk(0, 0, NS_RET,  0,  0, 0, 0, 0, 0, 0, 21, 0, 0));
`else
    tbl.push_back(mk(0, 0, NS_JMP,  0, 10, 0, 0, 0, 0, 0, 10, 0, 0));
    tbl.push_back(mk(0, 0, NS_CALL, 0, 50, 0, 0, 0, 0, 0, 61, 1, 0));
    tbl.push_back(mk(0, 0, NS_INC,  0,  0, 0, 0, 0, 0, 0, 62, 0, 0));
    tbl.push_back(mk(0, 0, NS_RET,  0,  0, 0, 0, 0, 0, 0, 61, 1, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // watchdog expiry after 15 waiting cycles, one-cycle trap
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "to_jmp");
    waits(14, 20, "to_wait");
    step(0, 0, NS_WAIT, 0, 0, 61, 1, 1, "to_trap");
    step(0, 0, NS_INC, 0, 0, 62, 0, 0, "to_after");

    // moc on the 15th cycle wins, and the count restarts afterwards
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "moc15_jmp");
    waits(14, 20, "moc15_wait");
    step(0, 0, NS_WAIT, 0, 1, 21, 0, 0, "moc15_done");
    waits(14, 21, "moc15_rewait");
    step(0, 0, NS_WAIT, 0, 0, 61, 1, 1, "moc15_trap");

    // a non-waiting cycle clears the count
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "clr_jmp");
    waits(10, 20, "clr_wait");
    step(0, 0, NS_INC, 0, 0, 21, 0, 0, "clr_inc");
    waits(14, 21, "clr_rewait");
    step(0, 0, NS_WAIT, 0, 0, 61, 1, 1, "clr_trap");

    // hold freezes state and watchdog, suppresses trap
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "hold_jmp");
    waits(5, 20, "hold_pre");
    for (int i = 0; i < 5; i++) step(0, 1, NS_WAIT, 0, 0, 20, 0, 1, "hold_wait");
    step(0, 1, NS_JMP, 3, 0, 20, 0, 0, "hold_jmp3");
    waits(9, 20, "hold_post");
    step(0, 1, NS_WAIT, 0, 0, 20, 0, 1, "hold_at_limit");
    step(0, 0, NS_WAIT, 0, 0, 61, 1, 1, "hold_trap");

    // reset mid-wait clears the watchdog without a trap
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "rst_jmp");
    waits(14, 20, "rst_wait");
    step(1, 0, NS_WAIT, 0, 0, 0, 0, 1, "rst_mid");
    step(0, 0, NS_JMP, 20, 0, 20, 0, 0, "rst_jmp2");
    waits(14, 20, "rst_rewait");
    step(0, 0, NS_WAIT, 0, 0, 61, 1, 1, "rst_trap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
